// File: rtl/exc_seq.sv
// Exception/interrupt sequencer: saves state, fetches the vector over MIO and loads the PC.
// Optional macro EXC_IRQ_EDGE_EN switches irq lines to rising-edge detection with pending latches.
module exc_seq #(
  parameter int          N_SRC    = 4,
  parameter int          CAUSE_W  = 5,
  parameter logic [31:0] VEC_BASE = 32'h0000_0004,
  parameter int          MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq,
  input  logic               syscall,
  input  logic               eret,
  input  logic               boundary,
  input  logic [31:0]        cp0_status,
  input  logic               MIO_ready,
  input  logic [31:0]        mem_data,
  output logic               int_pending,
  output logic               busy,
  output logic               mem_rd,
  output logic               CPU_MIO,
  output logic [31:0]        vec_addr,
  output logic [CAUSE_W-1:0] cause,
  output logic               wepc,
  output logic               wcau,
  output logic               wsta,
  output logic               exc,
  output logic               inta,
  output logic               pc_load,
  output logic [31:0]        pc_val,
  output logic               vec_err
);

  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [2:0] {IDLE, SAVE, VEC_RD, LOAD_PC, RESTORE} state_t;

  state_t             state;
  logic [N_SRC-1:0]   mask;
  logic [N_SRC-1:0]   req_lines;
  logic [N_SRC-1:0]   active;
  logic               hw_req;
  logic [SRC_W-1:0]   sel_idx;
  logic [SRC_W-1:0]   src;
  logic               is_sys;
  logic [15:0]        wait_cnt;

  assign mask = cp0_status[8 +: N_SRC];

`ifdef EXC_IRQ_EDGE_EN
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_clr;

  always_comb begin
    pend_clr = '0;
    if (state == SAVE && !is_sys) pend_clr[src] = 1'b1;
  end

  // A fresh edge in the same cycle as the clear keeps the latch set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pend     <= '0;
    end else begin
      irq_prev <= irq;
      pend     <= (pend & ~pend_clr) | (irq & ~irq_prev);
    end
  end

  assign req_lines = pend;
`else
  assign req_lines = irq;
`endif

  assign active      = req_lines & mask;
  assign hw_req      = cp0_status[0] & ~cp0_status[1] & (|active);
  assign int_pending = hw_req | syscall;

  always_comb begin
    sel_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel_idx = SRC_W'(i);
    end
  end

  // Outputs are loaded together with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      src      <= '0;
      is_sys   <= 1'b0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      mem_rd   <= 1'b0;
      CPU_MIO  <= 1'b0;
      vec_addr <= '0;
      cause    <= '0;
      wepc     <= 1'b0;
      wcau     <= 1'b0;
      wsta     <= 1'b0;
      exc      <= 1'b0;
      inta     <= 1'b0;
      pc_load  <= 1'b0;
      pc_val   <= '0;
      vec_err  <= 1'b0;
    end else begin
      wepc    <= 1'b0;
      wcau    <= 1'b0;
      wsta    <= 1'b0;
      exc     <= 1'b0;
      inta    <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        IDLE: begin
          if (boundary && syscall) begin
            state  <= SAVE;
            is_sys <= 1'b1;
            cause  <= CAUSE_W'(8);
            busy   <= 1'b1;
            wepc   <= 1'b1;
            wcau   <= 1'b1;
            wsta   <= 1'b1;
            exc    <= 1'b1;
          end else if (boundary && eret) begin
            state   <= RESTORE;
            cause   <= '0;
            busy    <= 1'b1;
            wsta    <= 1'b1;
            pc_load <= 1'b1;
            pc_val  <= '0;
          end else if (boundary && hw_req) begin
            state  <= SAVE;
            is_sys <= 1'b0;
            src    <= sel_idx;
            cause  <= CAUSE_W'(16) + CAUSE_W'(sel_idx);
            busy   <= 1'b1;
            wepc   <= 1'b1;
            wcau   <= 1'b1;
            wsta   <= 1'b1;
            exc    <= 1'b1;
            inta   <= 1'b1;
          end
        end
        SAVE: begin
          state    <= VEC_RD;
          wait_cnt <= '0;
          mem_rd   <= 1'b1;
          CPU_MIO  <= 1'b1;
          vec_addr <= is_sys ? VEC_BASE : VEC_BASE + ((32'(src) + 32'd1) << 2);
        end
        VEC_RD: begin
          if (MIO_ready || wait_cnt == 16'(MAX_WAIT - 1)) begin
            state    <= LOAD_PC;
            mem_rd   <= 1'b0;
            CPU_MIO  <= 1'b0;
            vec_addr <= '0;
            pc_load  <= 1'b1;
            if (MIO_ready) begin
              pc_val <= mem_data;
            end else begin
              pc_val  <= VEC_BASE;
              vec_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        LOAD_PC, RESTORE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_seq.sv
// Randomised bench for exc_seq against a cycle-level behavioural model, plus directed scenarios.
// Honours EXC_IRQ_EDGE_EN to model edge-detected interrupt lines.
module tb_exc_seq;

  localparam int          N_SRC    = 4;
  localparam int          CAUSE_W  = 5;
  localparam logic [31:0] VEC_BASE = 32'h0000_0004;
  localparam int          MAX_WAIT = 255;
`ifdef EXC_IRQ_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N_SRC-1:0]   irq = '0;
  logic               syscall = 1'b0;
  logic               eret = 1'b0;
  logic               boundary = 1'b0;
  logic [31:0]        cp0_status = '0;
  logic               MIO_ready = 1'b0;
  logic [31:0]        mem_data = '0;
  logic               int_pending, busy, mem_rd, CPU_MIO;
  logic [31:0]        vec_addr, pc_val;
  logic [CAUSE_W-1:0] cause;
  logic               wepc, wcau, wsta, exc, inta, pc_load, vec_err;

  exc_seq #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W), .VEC_BASE(VEC_BASE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .irq(irq), .syscall(syscall), .eret(eret),
    .boundary(boundary), .cp0_status(cp0_status), .MIO_ready(MIO_ready),
    .mem_data(mem_data), .int_pending(int_pending), .busy(busy), .mem_rd(mem_rd),
    .CPU_MIO(CPU_MIO), .vec_addr(vec_addr), .cause(cause), .wepc(wepc), .wcau(wcau),
    .wsta(wsta), .exc(exc), .inta(inta), .pc_load(pc_load), .pc_val(pc_val),
    .vec_err(vec_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one sequence in flight at a time; kind 1 = syscall, 2 = irq, 3 = eret.
  bit               m_on = 0;
  int               m_kind = 0;
  bit               m_saving = 0;
  bit               m_loading = 0;
  int               m_waits = 0;
  int               m_src = 0;
  logic [31:0]      m_pc = '0;
  logic [CAUSE_W-1:0] m_cause = '0;
  bit               m_err = 0;
  logic [N_SRC-1:0] m_pend = '0;
  logic [N_SRC-1:0] m_prev = '0;

  function automatic logic [N_SRC-1:0] enabledReqs();
    logic [N_SRC-1:0] lines;
    lines = EDGE ? m_pend : irq;
    return lines & cp0_status[8 +: N_SRC];
  endfunction

  function automatic bit hwReq();
    return cp0_status[0] && !cp0_status[1] && (|enabledReqs());
  endfunction

  function automatic int lowestIdx();
    logic [N_SRC-1:0] r;
    r = enabledReqs();
    for (int i = 0; i < N_SRC; i++) if (r[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    m_on = 0; m_kind = 0; m_saving = 0; m_loading = 0; m_waits = 0; m_src = 0;
    m_pc = '0; m_cause = '0; m_err = 0; m_pend = '0; m_prev = '0;
  endtask

  task automatic modelStep();
    logic [N_SRC-1:0] clr;
    bit hw;
    int idx;
    clr = '0;
    if (m_on && m_saving && m_kind == 2) clr[m_src] = 1'b1;
    hw  = hwReq();
    idx = lowestIdx();
    if (!m_on) begin
      if (boundary && syscall) begin
        m_on = 1; m_kind = 1; m_saving = 1; m_loading = 0; m_cause = 8;
      end else if (boundary && eret) begin
        m_on = 1; m_kind = 3; m_saving = 0; m_loading = 0; m_cause = 0; m_pc = 0;
      end else if (boundary && hw) begin
        m_on = 1; m_kind = 2; m_saving = 1; m_loading = 0; m_src = idx;
        m_cause = CAUSE_W'(16 + idx);
      end
    end else if (m_kind == 3 || m_loading) begin
      m_on = 0; m_loading = 0;
    end else if (m_saving) begin
      m_saving = 0; m_waits = 0;
    end else if (MIO_ready) begin
      m_pc = mem_data; m_loading = 1;
    end else if (m_waits + 1 == MAX_WAIT) begin
      m_pc = VEC_BASE; m_err = 1; m_loading = 1;
    end else begin
      m_waits++;
    end
    m_pend = (m_pend & ~clr) | (irq & ~m_prev);
    m_prev = irq;
  endtask

  task automatic compareAll();
    bit save, rd, restore;
    logic [31:0] exp_addr;
    save     = m_on && m_saving;
    restore  = m_on && m_kind == 3;
    rd       = m_on && m_kind != 3 && !m_saving && !m_loading;
    exp_addr = !rd ? 32'h0 : (m_kind == 1 ? VEC_BASE : VEC_BASE + 32'(4 * (m_src + 1)));
    checkOutput("busy", 32'(busy), 32'(m_on));
    checkOutput("wepc", 32'(wepc), 32'(save));
    checkOutput("wcau", 32'(wcau), 32'(save));
    checkOutput("exc", 32'(exc), 32'(save));
    checkOutput("inta", 32'(inta), 32'(save && m_kind == 2));
    checkOutput("wsta", 32'(wsta), 32'(save || restore));
    checkOutput("mem_rd", 32'(mem_rd), 32'(rd));
    checkOutput("CPU_MIO", 32'(CPU_MIO), 32'(rd));
    checkOutput("vec_addr", vec_addr, exp_addr);
    checkOutput("pc_load", 32'(pc_load), 32'((m_on && m_loading) || restore));
    checkOutput("pc_val", pc_val, m_pc);
    checkOutput("cause", 32'(cause), 32'(m_cause));
    checkOutput("vec_err", 32'(vec_err), 32'(m_err));
    checkOutput("int_pending", 32'(int_pending), 32'(hwReq() || syscall));
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      modelReset();
    end else begin
      modelStep();
      #1;
      if (!reset) compareAll();
    end
  end

  task automatic applyStimulus(input bit bnd, input bit sys, input bit er,
                               input logic [N_SRC-1:0] irq_v, input logic [31:0] st,
                               input bit rdy, input logic [31:0] data);
    @(negedge clk);
    boundary = bnd; syscall = sys; eret = er; irq = irq_v;
    cp0_status = st; MIO_ready = rdy; mem_data = data;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    boundary = 0; syscall = 0; eret = 0; irq = '0; MIO_ready = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int vr;
    int n;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_cause", 32'(cause), 32'h0);
    reset = 1'b0;

    // Lowest enabled active irq wins: irq=0110 -> source 1.
    doReset();
    applyStimulus(0, 0, 0, 4'b0110, 32'h0000_0F01, 1, 32'h200);
    applyStimulus(1, 0, 0, 4'b0110, 32'h0000_0F01, 1, 32'h200);
    applyStimulus(0, 0, 0, 4'b0110, 32'h0000_0F01, 1, 32'h200);
    checkOutput("t1_cause", 32'(cause), 32'd17);
    checkOutput("t1_inta", 32'(inta), 32'h1);
    applyStimulus(0, 0, 0, 4'b0110, 32'h0000_0F01, 1, 32'h200);
    checkOutput("t1_vec_addr", vec_addr, 32'h0000_000C);
    applyStimulus(0, 0, 0, 4'b0110, 32'h0000_0F01, 1, 32'h200);
    checkOutput("t1_pc_load", 32'(pc_load), 32'h1);
    checkOutput("t1_pc_val", pc_val, 32'h200);

    // Syscall with interrupts disabled.
    doReset();
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F00, 1, 32'h300);
    applyStimulus(1, 1, 0, 4'b0001, 32'h0000_0F00, 1, 32'h300);
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F00, 1, 32'h300);
    checkOutput("t2_cause", 32'(cause), 32'd8);
    checkOutput("t2_inta", 32'(inta), 32'h0);
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F00, 1, 32'h300);
    checkOutput("t2_vec_addr", vec_addr, 32'h0000_0004);

    // Eret beats irq at the same boundary; irq taken at the next one.
    doReset();
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h400);
    applyStimulus(1, 0, 1, 4'b0001, 32'h0000_0F01, 1, 32'h400);
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h400);
    checkOutput("t3_wsta", 32'(wsta), 32'h1);
    checkOutput("t3_pc_load", 32'(pc_load), 32'h1);
    checkOutput("t3_pc_val", pc_val, 32'h0);
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h400);
    applyStimulus(1, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h400);
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h400);
    checkOutput("t3_cause", 32'(cause), 32'd16);
    repeat (3) applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h400);

    // Vector fetch timeout with MIO_ready held low.
    doReset();
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 0, 32'h500);
    applyStimulus(1, 0, 0, 4'b0001, 32'h0000_0F01, 0, 32'h500);
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 0, 32'h500);
    vr = 0;
    n = 0;
    while (!pc_load && n < 400) begin
      applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 0, 32'h500);
      if (mem_rd) vr++;
      n++;
    end
    checkOutput("t4_pc_load", 32'(pc_load), 32'h1);
    checkOutput("t4_wait_cycles", 32'(vr), 32'd255);
    checkOutput("t4_pc_val", pc_val, VEC_BASE);
    checkOutput("t4_vec_err", 32'(vec_err), 32'h1);
    repeat (45) applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 0, 32'h500);
    applyStimulus(1, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h500);
    repeat (4) applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h500);
    checkOutput("t4_vec_err_sticky", 32'(vec_err), 32'h1);

    // Reset in the middle of the vector read aborts the sequence.
    doReset();
    applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 0, 32'h600);
    applyStimulus(1, 0, 0, 4'b0001, 32'h0000_0F01, 0, 32'h600);
    repeat (3) applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 0, 32'h600);
    checkOutput("t5_mem_rd_before", 32'(mem_rd), 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_mem_rd", 32'(mem_rd), 32'h0);
    checkOutput("t5_busy", 32'(busy), 32'h0);
    checkOutput("t5_cause", 32'(cause), 32'h0);
    checkOutput("t5_vec_err", 32'(vec_err), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 4'b0001, 32'h0000_0F01, 1, 32'h600);
      checkOutput("t5_no_pc_load", 32'(pc_load), 32'h0);
    end

`ifdef EXC_IRQ_EDGE_EN
    // Edge captured while EXL is set is serviced once, not again while the line stays high.
    doReset();
    applyStimulus(0, 0, 0, 4'b0100, 32'h0000_0F03, 1, 32'h700);
    applyStimulus(0, 0, 0, 4'b0100, 32'h0000_0F03, 1, 32'h700);
    applyStimulus(1, 0, 0, 4'b0100, 32'h0000_0F01, 1, 32'h700);
    applyStimulus(0, 0, 0, 4'b0100, 32'h0000_0F01, 1, 32'h700);
    checkOutput("t6_cause", 32'(cause), 32'd18);
    repeat (4) applyStimulus(0, 0, 0, 4'b0100, 32'h0000_0F01, 1, 32'h700);
    applyStimulus(1, 0, 0, 4'b0100, 32'h0000_0F01, 1, 32'h700);
    applyStimulus(0, 0, 0, 4'b0100, 32'h0000_0F01, 1, 32'h700);
    checkOutput("t6_no_reentry", 32'(busy), 32'h0);
`endif

    // Randomised traffic against the model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] st;
      st = {20'h0, 4'($urandom), 6'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
      if ($urandom_range(0, 499) == 0) doReset();
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, N_SRC'($urandom), st,
                    $urandom_range(0, 3) != 0, $urandom);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
